pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//   Program-counter and fetch sequencer for the multi-cycle/pipelined Mini-MIPS core.
//   Replaces the free-running PC latch with the following features:
//   - variable-latency imem req/ack handshake
//   - decode stall
//   - branch/jump redirect
//   - exception entry with EPC capture
//   - ERET
//   Sits between the hazard/branch logic and instruction memory. Delivers {pc, valid} to IF/ID.
// PARAMETERS
//   WIDTH         32            address width in bits
//   RESET_VECTOR  32'h0000_0000 first fetch address after reset
//   EXC_VECTOR    32'h8000_0180 exception handler entry address
//   INSTR_BYTES   4             sequential increment; power of two; alignment = log2(INSTR_BYTES)
// PORTS
//   clk             input   1      rising-edge clock
//   reset           input   1      asynchronous, active-high
//   stall           input   1      hold: do not launch the next fetch
//   redirect_valid  input   1      branch/jump taken this cycle
//   redirect_pc     input   WIDTH  redirect target
//   exc_valid       input   1      exception raised this cycle
//   exc_pc          input   WIDTH  PC of faulting instruction (written to epc)
//   eret            input   1      return from exception to epc
//   imem_req        output  1      fetch request; held until imem_ack
//   imem_addr       output  WIDTH  fetch address; stable while imem_req=1 and no ack
//   imem_ack        input   1      memory accepted request and returned data this cycle
//   fetch_valid     output  1      1-cycle pulse: instruction at pc_out is valid
//   pc_out          output  WIDTH  PC of delivered instruction
//   epc             output  WIDTH  exception PC register
//   misalign_err    output  1      1-cycle pulse: redirect/eret target was misaligned
// BEHAVIOUR
//   Reset (async, active-high): asynchronous assert, synchronous release.
//     - State=BOOT, imem_req=0, imem_addr=RESET_VECTOR.
//     - fetch_valid=0, pc_out=0, epc=0, misalign_err=0.
//   States: BOOT, FETCH, DRAIN, HOLD.
//     BOOT  -> FETCH on the first cycle after reset release. imem_req rises that cycle with addr=RESET_VECTOR.
//     FETCH: imem_req=1.
//       On ack with no control event: fetch_valid=1 and pc_out=imem_addr in the same cycle
//       (combinational from ack; pc_out is registered one cycle later for IF/ID).
//       Next addr = addr + INSTR_BYTES, modulo 2^WIDTH (FFFF_FFFC -> 0000_0000).
//       If stall=1 on ack, go to HOLD instead of re-requesting.
//     HOLD: imem_req=0; next addr held. Returns to FETCH the first cycle stall=0.
//     DRAIN: entered when a control event arrives while a request is outstanding and ack=0.
//       - imem_req stays 1 and imem_addr stays unchanged (protocol: never retract).
//       - On ack: the returned data is discarded (fetch_valid=0); go to FETCH at the pending target.
//       - Later events in DRAIN overwrite the pending target by priority.
//   Control event priority: exc_valid > eret > redirect_valid > stall > sequential.
//     - exc_valid: target=EXC_VECTOR; epc <= exc_pc on the same edge.
//     - eret: target=epc.
//     - redirect: target=redirect_pc.
//   Event on the same cycle as ack: ack data discarded; next request launches at the target on the next cycle.
//   Event while in HOLD or BOOT: target replaces the held addr; stall still gates the launch.
//   Misalignment: a target with low log2(INSTR_BYTES) bits nonzero is forced-aligned (bits cleared),
//     and misalign_err pulses for 1 cycle. EXC_VECTOR must be aligned (checked at elaboration).
//   Latency:
//     - ack -> fetch_valid: 0 cycles.
//     - ack -> next imem_req: 1 cycle.
//     - redirect -> first valid target fetch: 1 cycle + memory latency.
//   Reset mid-DRAIN or mid-request: all pending state dropped. A late ack after reset is ignored in BOOT.
// STRUCTURE
//   Shared package mini_mips_pkg:
//     - fetch_state_t enum {BOOT, FETCH, DRAIN, HOLD}
//     - INSTR_BYTES_DEFAULT
//     - EXC_VECTOR_DEFAULT
//     - RESET_VECTOR_DEFAULT
//   Sub-module pc_next_sel: combinational priority mux producing {target, target_valid, misalign} from the control inputs.
//   The state machine, address, epc and pending-target registers live in pc_fetch_unit.
// TESTING
//   - Sequential fetch: release reset, ack every cycle.
//     Expect addr 0,4,8,C; fetch_valid pulses with pc_out matching; no gaps beyond 1 cycle.
//   - Wrap-around: redirect_pc=FFFF_FFFC, ack.
//     Expect next imem_addr=0000_0000.
//   - Redirect during a 3-cycle memory wait: redirect_pc=0x40 in wait cycle 1.
//     Expect addr held until ack, fetch_valid=0 on that ack, next request addr=0x40.
//   - Priority: exc_valid, eret and redirect in the same cycle with exc_pc=0x20.
//     Expect epc=0x20 and next addr=8000_0180. A later eret yields addr 0x20.
//   - Stall + misalign: stall=1 on ack, imem_req=0 for 3 cycles, then redirect 0x102.
//     Expect addr 0x100 and misalign_err pulse. Release stall: request launches.
//   - Async reset asserted mid-DRAIN.
//     Expect immediate imem_req=0 and epc=0; restart fetch at RESET_VECTOR.

Source files
------------

// File: rtl/mini_mips_pkg.sv
// Shared Mini-MIPS definitions used by the fetch front end.
//   fetch_state_t         fetch sequencer states
//   INSTR_BYTES_DEFAULT   bytes per instruction (sequential PC increment)
//   EXC_VECTOR_DEFAULT    exception handler entry address
//   RESET_VECTOR_DEFAULT  first fetch address after reset
package mini_mips_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;

  localparam int          INSTR_BYTES_DEFAULT  = 4;
  localparam logic [31:0] EXC_VECTOR_DEFAULT   = 32'h8000_0180;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch handshake.
//   req   fetch request, held by the master until ack
//   addr  fetch address, stable while req=1 and ack=0
//   ack   memory accepted the request and returned data this cycle
// Modports: master = fetch unit, slave = instruction memory.
interface pc_fetch_unit_if #(
  parameter int WIDTH = 32
) ();

  logic             req;
  logic [WIDTH-1:0] addr;
  logic             ack;

  modport master (output req, output addr, input ack);
  modport slave  (input req, input addr, output ack);

endinterface

// File: rtl/pc_next_sel.sv
// Control-event priority mux for the fetch unit.
// Picks the redirect target from exc_valid > eret > redirect_valid,
// force-aligns it to the instruction size and flags a misaligned request.
//   exc_valid, eret, redirect_valid  control events this cycle
//   redirect_pc                      branch/jump target
//   epc                              current exception PC (eret target)
//   target                           aligned target address
//   target_valid                     any control event present
//   misalign                         selected target had low bits set
module pc_next_sel
  import mini_mips_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] EXC_VECTOR  = WIDTH'(EXC_VECTOR_DEFAULT),
  parameter int               INSTR_BYTES = INSTR_BYTES_DEFAULT
) (
  input  logic             exc_valid,
  input  logic             eret,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] target,
  output logic             target_valid,
  output logic             misalign
);

  localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(INSTR_BYTES - 1);

  logic [WIDTH-1:0] raw;

  always_comb begin
    raw = redirect_pc;
    if (exc_valid) begin
      raw = EXC_VECTOR;
    end else if (eret) begin
      raw = epc;
    end
    target_valid = exc_valid | eret | redirect_valid;
    target       = raw & ~LOW_MASK;
    misalign     = target_valid && ((raw & LOW_MASK) != '0);
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter and fetch sequencer for the Mini-MIPS core.
// Issues instruction fetches over a variable-latency req/ack handshake,
// honours decode stall, branch/jump redirect, exception entry (EPC capture)
// and ERET, and delivers {pc_out, fetch_valid} to IF/ID.
//   clk, reset      rising-edge clock; async active-high reset (release is
//                   expected to be synchronised to clk upstream)
//   stall           do not launch the next fetch
//   redirect_valid  branch/jump taken, target redirect_pc
//   exc_valid       exception, target EXC_VECTOR, epc <= exc_pc
//   eret            return to epc
//   imem            fetch handshake (master side)
//   fetch_valid     instruction at pc_out is valid (combinational from ack)
//   pc_out          PC of the delivered instruction, held between deliveries
//   epc             exception PC register
//   misalign_err    1-cycle pulse after a misaligned redirect/eret target
module pc_fetch_unit
  import mini_mips_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(RESET_VECTOR_DEFAULT),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(EXC_VECTOR_DEFAULT),
  parameter int               INSTR_BYTES  = INSTR_BYTES_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [WIDTH-1:0]    redirect_pc,
  input  logic                exc_valid,
  input  logic [WIDTH-1:0]    exc_pc,
  input  logic                eret,
  pc_fetch_unit_if.master     imem,
  output logic                fetch_valid,
  output logic [WIDTH-1:0]    pc_out,
  output logic [WIDTH-1:0]    epc,
  output logic                misalign_err
);

  localparam logic [1:0] ST_BOOT  = BOOT;
  localparam logic [1:0] ST_FETCH = FETCH;
  localparam logic [1:0] ST_DRAIN = DRAIN;
  localparam logic [1:0] ST_HOLD  = HOLD;

  localparam logic [WIDTH-1:0] INC = WIDTH'(INSTR_BYTES);

  if ((INSTR_BYTES < 1) || ((INSTR_BYTES & (INSTR_BYTES - 1)) != 0)) begin : g_bad_instr_bytes
    $error("pc_fetch_unit: INSTR_BYTES must be a power of two");
  end
  if ((EXC_VECTOR & WIDTH'(INSTR_BYTES - 1)) != '0) begin : g_bad_exc_vector
    $error("pc_fetch_unit: EXC_VECTOR must be instruction aligned");
  end

  logic [1:0]       state;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] pc_p1;
  logic [WIDTH-1:0] target;
  logic             target_valid;
  logic             misalign;

  pc_next_sel #(
    .WIDTH       (WIDTH),
    .EXC_VECTOR  (EXC_VECTOR),
    .INSTR_BYTES (INSTR_BYTES)
  ) u_next_sel (
    .exc_valid      (exc_valid),
    .eret           (eret),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .epc            (epc),
    .target         (target),
    .target_valid   (target_valid),
    .misalign       (misalign)
  );

  // A request is outstanding in FETCH and DRAIN; it is never retracted.
  assign imem.req  = (state == ST_FETCH) || (state == ST_DRAIN);
  assign imem.addr = addr;

  // Only a plain FETCH ack delivers; DRAIN acks and acks coinciding with a
  // control event carry data for a path that has been abandoned.
  assign fetch_valid = (state == ST_FETCH) && imem.ack && !target_valid;
  assign pc_out      = fetch_valid ? addr : pc_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_BOOT;
      addr         <= RESET_VECTOR;
      pending      <= RESET_VECTOR;
      pc_p1        <= '0;
      epc          <= '0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= misalign;
      if (exc_valid) begin
        epc <= exc_pc;
      end
      if (fetch_valid) begin
        pc_p1 <= addr;
      end
      case (state)
        // No request outstanding: events retarget the next launch, stall gates it.
        ST_BOOT, ST_HOLD: begin
          if (target_valid) begin
            addr <= target;
          end
          state <= stall ? ST_HOLD : ST_FETCH;
        end
        ST_FETCH: begin
          if (imem.ack) begin
            addr  <= target_valid ? target : addr + INC;
            state <= stall ? ST_HOLD : ST_FETCH;
          end else if (target_valid) begin
            // Address must stay put until the memory answers; park the target.
            pending <= target;
            state   <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (target_valid) begin
            pending <= target;
          end
          if (imem.ack) begin
            addr  <= target_valid ? target : pending;
            state <= stall ? ST_HOLD : ST_FETCH;
          end
        end
        default: state <= ST_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit: directed scenarios followed by random control
// traffic, all compared against a behavioural fetch model.
module tb_pc_fetch_unit;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] XV = 32'h8000_0180;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        exc_valid;
  logic [31:0] exc_pc;
  logic        eret;
  logic        fetch_valid;
  logic [31:0] pc_out;
  logic [31:0] epc;
  logic        misalign_err;

  always #5 clk = ~clk;

  pc_fetch_unit_if #(.WIDTH(32)) imem_bus ();

  pc_fetch_unit #(
    .WIDTH        (32),
    .RESET_VECTOR (RV),
    .EXC_VECTOR   (XV),
    .INSTR_BYTES  (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .exc_valid      (exc_valid),
    .exc_pc         (exc_pc),
    .eret           (eret),
    .imem           (imem_bus),
    .fetch_valid    (fetch_valid),
    .pc_out         (pc_out),
    .epc            (epc),
    .misalign_err   (misalign_err)
  );

  int checks = 0;
  int errors = 0;

  // Model: "busy" = a request is out; "discard" = its data belongs to an
  // abandoned path and the fetch continues at "pend" once it returns.
  bit          m_busy;
  bit          m_discard;
  bit          m_mis;
  logic [31:0] m_addr;
  logic [31:0] m_pend;
  logic [31:0] m_epc;
  logic [31:0] m_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy    = 1'b0;
    m_discard = 1'b0;
    m_mis     = 1'b0;
    m_addr    = RV;
    m_pend    = RV;
    m_epc     = 32'h0;
    m_last    = 32'h0;
  endtask

  // One clock cycle: drive inputs just after the edge, check mid-cycle,
  // advance the model, move to just after the next edge.
  task automatic step(input bit s, input bit rv, input logic [31:0] rpc,
                      input bit ex, input logic [31:0] xpc, input bit er, input bit ak);
    bit          ev;
    bit          fv;
    logic [31:0] raw;
    logic [31:0] tgt;
    stall          = s;
    redirect_valid = rv;
    redirect_pc    = rpc;
    exc_valid      = ex;
    exc_pc         = xpc;
    eret           = er;
    imem_bus.ack   = ak;
    ev  = ex | er | rv;
    raw = ex ? XV : (er ? m_epc : rpc);
    tgt = raw & 32'hFFFF_FFFC;
    fv  = m_busy && !m_discard && ak && !ev;
    #4;
    chk("imem_req", imem_bus.req, m_busy);
    chk("imem_addr", imem_bus.addr, m_addr);
    chk("fetch_valid", fetch_valid, fv);
    chk("pc_out", pc_out, fv ? m_addr : m_last);
    chk("epc", epc, m_epc);
    chk("misalign_err", misalign_err, m_mis);
    if (fv) m_last = m_addr;
    m_mis = ev && ((raw % 4) != 0);
    if (ex) m_epc = xpc;
    if (!m_busy) begin
      if (ev) m_addr = tgt;
      m_busy = !s;
    end else if (ak) begin
      if (ev) m_addr = tgt;
      else if (m_discard) m_addr = m_pend;
      else m_addr = m_addr + 32'd4;
      m_busy    = !s;
      m_discard = 1'b0;
    end else if (ev) begin
      m_pend    = tgt;
      m_discard = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    exc_valid      = 1'b0;
    exc_pc         = 32'h0;
    eret           = 1'b0;
    imem_bus.ack   = 1'b0;
    model_reset();
    #1;
    chk("rst_req", imem_bus.req, 1'b0);
    chk("rst_addr", imem_bus.addr, RV);
    chk("rst_fetch_valid", fetch_valid, 1'b0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_misalign", misalign_err, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Sequential fetch
    step(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 1);
    chk("seq_addr", imem_bus.addr, 32'h10);

    // Wrap-around
    step(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("wrap_addr", imem_bus.addr, 32'h0);

    // Redirect during a 3-cycle memory wait
    step(0, 1, 32'h40, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("drain_addr", imem_bus.addr, 32'h40);
    chk("drain_req", imem_bus.req, 1'b1);

    // Priority: exception beats eret and redirect
    step(0, 1, 32'h300, 1, 32'h20, 1, 1);
    chk("prio_epc", epc, 32'h20);
    chk("prio_addr", imem_bus.addr, XV);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    chk("eret_addr", imem_bus.addr, 32'h20);

    // Stall on ack, redirect to a misaligned target while held
    step(1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      chk("hold_req", imem_bus.req, 1'b0);
      step(1, 0, 0, 0, 0, 0, 0);
    end
    step(1, 1, 32'h102, 0, 0, 0, 0);
    chk("mis_addr", imem_bus.addr, 32'h100);
    chk("mis_pulse", misalign_err, 1'b1);
    chk("mis_req", imem_bus.req, 1'b0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("release_req", imem_bus.req, 1'b1);
    chk("release_addr", imem_bus.addr, 32'h100);

    // Random control traffic
    for (int i = 0; i < 400; i++) begin
      bit          s, rv, ex, er, ak;
      logic [31:0] rpc, xpc;
      s   = ($urandom_range(0, 99) < 15);
      rv  = ($urandom_range(0, 99) < 10);
      ex  = ($urandom_range(0, 99) < 4);
      er  = ($urandom_range(0, 99) < 4);
      ak  = ($urandom_range(0, 99) < 55);
      rpc = $urandom;
      xpc = $urandom;
      step(s, rv, rpc, ex, xpc, er, ak);
    end

    // Async reset in the middle of a drain
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h44, 0, 0);
    chk("pre_rst_epc", epc, 32'h44);
    chk("pre_rst_req", imem_bus.req, 1'b1);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_req", imem_bus.req, 1'b0);
    chk("arst_epc", epc, 32'h0);
    chk("arst_addr", imem_bus.addr, RV);
    model_reset();
    imem_bus.ack = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 1);
    chk("restart_addr", imem_bus.addr, 32'hC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
